// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch levels in, debounced level and edge pulses out.
interface switch_debouncer_if #(parameter int WIDTH = 10);
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] SW_DB;
    logic [WIDTH-1:0] SW_RISE;
    logic [WIDTH-1:0] SW_FALL;
    logic             SW_CHANGED;
    modport master (output SW, input SW_DB, SW_RISE, SW_FALL, SW_CHANGED);
    modport slave (input SW, output SW_DB, SW_RISE, SW_FALL, SW_CHANGED);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer plus per-bit tick-counted stability filter with rise/fall pulses.
module switch_debouncer #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input logic               CLOCK_50,
    input logic               RESET_N,
    switch_debouncer_if.slave sw_if
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]         s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0]         db_q, db_d, rise_q, rise_d, fall_q, fall_d;
    logic                     changed_q, changed_d;
    logic [PW-1:0]            pre_q, pre_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         acc;
    logic                     tick;

    always_comb begin
        s1_d = sw_if.SW;
        s2_d = s1_q;
        tick = pre_q == PRE_MAX;
        pre_d = tick ? '0 : pre_q + 1'b1;
        acc = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            acc[i] = tick && (s2_q[i] != db_q[i]) && (cnt_q[i] == CNT_MAX);
            // Counter only advances while the bit disagrees with the accepted level
            cnt_d[i] = (s2_q[i] == db_q[i] || acc[i]) ? '0 : tick ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
        db_d = db_q ^ acc;
        rise_d = acc & s2_q;
        fall_d = acc & ~s2_q;
        changed_d = |acc;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_if.SW_DB      = db_q;
    assign sw_if.SW_RISE    = rise_q;
    assign sw_if.SW_FALL    = fall_q;
    assign sw_if.SW_CHANGED = changed_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: table vectors, corner sequences and random stimulus against a run-length reference model.
module tb_switch_debouncer;
    localparam int W = 10, TD = 4, ST = 3;
    localparam int MINLAT = 2 + (ST - 1) * TD + 1, MAXLAT = 2 + ST * TD;

    logic CLOCK_50 = 1'b0;
    logic RESET_N = 1'b1;
    switch_debouncer_if #(.WIDTH(W)) sw_if ();
    switch_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sw_if(sw_if));

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [W-1:0] sw;
        int           hold;
        logic [W-1:0] db, rise, fall;
        int           nchg;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [W-1:0] m_db, m_rise, m_fall;
    logic [W-1:0] sync_q[$];
    int run[W];
    int k;
    int chg_cnt;
    logic [W-1:0] rise_acc, fall_acc;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int lo, int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic model_reset();
        m_db = '0; m_rise = '0; m_fall = '0; k = 0;
        sync_q = {};
        sync_q.push_back('0);
        sync_q.push_back('0);
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    // A bit is accepted on a tick once it has disagreed with the accepted level
    // for every cycle spanning ST consecutive ticks.
    task automatic model_edge();
        logic [W-1:0] s2, acc;
        s2 = sync_q.pop_front();
        sync_q.push_back(sw_if.SW);
        k++;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            run[i] = (s2[i] != m_db[i]) ? run[i] + 1 : 0;
            if (k % TD == 0 && run[i] > (ST - 1) * TD) begin
                acc[i] = 1'b1;
                run[i] = 0;
            end
        end
        m_rise = acc & s2;
        m_fall = acc & ~s2;
        m_db = m_db ^ acc;
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        if (RESET_N) model_edge();
        #1;
        check("SW_DB", sw_if.SW_DB, m_db);
        check("SW_RISE", sw_if.SW_RISE, m_rise);
        check("SW_FALL", sw_if.SW_FALL, m_fall);
        check("SW_CHANGED", W'(sw_if.SW_CHANGED), W'(|(m_rise | m_fall)));
        chg_cnt += int'(sw_if.SW_CHANGED);
        rise_acc |= sw_if.SW_RISE;
        fall_acc |= sw_if.SW_FALL;
    endtask

    task automatic clear_acc();
        chg_cnt = 0; rise_acc = '0; fall_acc = '0;
    endtask

    task automatic do_reset(int n);
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("rst_db", sw_if.SW_DB, '0);
        check("rst_pulse", sw_if.SW_RISE | sw_if.SW_FALL, '0);
        repeat (n) cyc();
        RESET_N = 1'b1;
    endtask

    task automatic measure(string name, logic [W-1:0] bit_mask);
        int lat;
        lat = 0;
        clear_acc();
        do begin
            cyc();
            lat++;
        end while ((sw_if.SW_DB & bit_mask) == '0 && lat < 40);
        check_int(name, lat, MINLAT, MAXLAT);
        check({name, "_rise"}, sw_if.SW_RISE, bit_mask);
        check({name, "_chg"}, W'(sw_if.SW_CHANGED), W'(1));
        cyc();
        check({name, "_rise_end"}, sw_if.SW_RISE, '0);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{10'h000, 100, 10'h000, 10'h000, 10'h000, 0};
        vt[1] = '{10'h3FF, 20, 10'h3FF, 10'h3FF, 10'h000, 1};
        vt[2] = '{10'h155, 20, 10'h155, 10'h000, 10'h2AA, 1};
        vt[3] = '{10'h000, 20, 10'h000, 10'h000, 10'h155, 1};
        vt[4] = '{10'h001, 20, 10'h001, 10'h001, 10'h000, 1};
        vt[5] = '{10'h2A1, 20, 10'h2A1, 10'h2A0, 10'h000, 1};
        vt[6] = '{10'h2A9, 5, 10'h2A1, 10'h000, 10'h000, 0};
        vt[7] = '{10'h2A1, 20, 10'h2A1, 10'h000, 10'h000, 0};

        sw_if.SW = '0;
        #2;
        do_reset(3);

        for (int v = 0; v < 8; v++) begin
            sw_if.SW = vt[v].sw;
            clear_acc();
            repeat (vt[v].hold) cyc();
            check($sformatf("vec%0d_db", v), sw_if.SW_DB, vt[v].db);
            check($sformatf("vec%0d_rise", v), rise_acc, vt[v].rise);
            check($sformatf("vec%0d_fall", v), fall_acc, vt[v].fall);
            check_int($sformatf("vec%0d_nchg", v), chg_cnt, vt[v].nchg, vt[v].nchg);
        end

        for (int p = 0; p < TD; p++) begin
            sw_if.SW = '0;
            do_reset(2);
            repeat (p) cyc();
            sw_if.SW = 10'h001;
            measure($sformatf("latency_ph%0d", p), 10'h001);
        end

        sw_if.SW = '0;
        do_reset(2);
        clear_acc();
        for (int b = 0; b < 5; b++) begin
            sw_if.SW = 10'h008;
            repeat (6) cyc();
            sw_if.SW = '0;
            repeat (2) cyc();
        end
        check("bounce_db", sw_if.SW_DB, '0);
        check_int("bounce_nchg", chg_cnt, 0, 0);
        sw_if.SW = 10'h008;
        clear_acc();
        repeat (20) cyc();
        check("bounce_hold_rise", rise_acc, 10'h008);
        check_int("bounce_hold_nchg", chg_cnt, 1, 1);

        sw_if.SW = '0;
        do_reset(2);
        sw_if.SW = 10'h020;
        clear_acc();
        repeat (8) cyc();
        do_reset(3);
        check("midpend_db", sw_if.SW_DB, '0);
        check_int("midpend_nchg", chg_cnt, 0, 0);
        measure("midpend_latency", 10'h020);

        sw_if.SW = 10'h2A1;
        do_reset(3);
        clear_acc();
        repeat (40) cyc();
        check("powerup_rise", rise_acc, 10'h2A1);
        check_int("powerup_nchg", chg_cnt, 1, 1);
        check("powerup_db", sw_if.SW_DB, 10'h2A1);

        sw_if.SW = '0;
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] x;
            x = W'($urandom) & W'($urandom) & W'($urandom);
            if ((c / 200) % 2 == 1) x = x & W'($urandom) & W'($urandom);
            sw_if.SW = sw_if.SW ^ x;
            if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
            else cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
